// File: rtl/act_buf_pkg.sv
// Shared types and helpers for the N-bank rotating activation buffer.
package act_buf_pkg;

  localparam int MIN_BANKS = 2;
  localparam int MAX_BANKS = 8;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Width of a bank index; never below 1 so ports stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Round-robin successor, wrapping n-1 -> 0.
  function automatic int next_bank(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/act_buf_bank.sv
// One activation SRAM bank: byte-strobed write port, registered read port.
module act_buf_bank #(
  parameter int TM         = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [TM*8-1:0]       wdata,
  input  logic [TM-1:0]         wstrb,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [TM*8-1:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [TM*8-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < TM; i++) begin
        if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/act_buffer_nbank.sv
// N-bank rotating activation buffer between host DMA (fill/commit) and array A-feed (drain/release).
module act_buffer_nbank
  import act_buf_pkg::*;
#(
  parameter int  NUM_BANKS  = 4,
  parameter int  TM         = 16,
  parameter int  ADDR_WIDTH = 7,
  localparam int CNT_W      = cnt_w(NUM_BANKS),
  localparam int BANK_W     = idx_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [TM*8-1:0]       wr_data,
  input  logic [TM-1:0]         wr_strb,
  input  logic                  wr_last,
  input  logic                  rd_en,
  output logic                  rd_avail,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_last,
  output logic [TM*8-1:0]       rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [BANK_W-1:0]     wr_bank,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [CNT_W-1:0]      full_count
);

  localparam int W = TM * 8;

  bank_state_e          bank_state [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_full;
  logic [W-1:0]         bank_rdata [NUM_BANKS];
  logic [BANK_W-1:0]    rd_bank_q;
  logic [W-1:0]         rd_hold;
  logic                 xfer_ok;
  logic                 wr_fire, rd_fire, wr_commit, rd_release;

  // Handshake: a write beat is wr_valid & wr_ready, a read beat is rd_en & rd_avail;
  // both are cancelled by rst/flush in the same cycle. rd_valid follows a read beat by one cycle.
  assign xfer_ok    = !(rst || flush);
  assign wr_ready   = !bank_full[wr_bank];
  assign rd_avail   = bank_full[rd_bank];
  assign wr_fire    = wr_valid && wr_ready && xfer_ok;
  assign rd_fire    = rd_en && rd_avail && xfer_ok;
  assign wr_commit  = wr_fire && wr_last;
  assign rd_release = rd_fire && rd_last;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign bank_full[g] = (bank_state[g] == BANK_FULL);

    act_buf_bank #(.TM(TM), .ADDR_WIDTH(ADDR_WIDTH)) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wr_bank == BANK_W'(g))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .wstrb (wr_strb),
      .re    (rd_fire && (rd_bank == BANK_W'(g))),
      .raddr (rd_addr),
      .rdata (bank_rdata[g])
    );
  end

  // Banks drive their registered word only on the valid cycle; otherwise the last word is held.
  assign rd_data = rd_valid ? bank_rdata[rd_bank_q] : rd_hold;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_BANKS; i++) bank_state[i] <= BANK_EMPTY;
      wr_bank    <= '0;
      rd_bank    <= '0;
      rd_bank_q  <= '0;
      full_count <= '0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      rd_hold    <= '0;
    end else begin
      if (wr_commit) begin
        bank_state[wr_bank] <= BANK_FULL;
        wr_bank             <= BANK_W'(next_bank(int'(wr_bank), NUM_BANKS));
      end
      if (rd_release) begin
        bank_state[rd_bank] <= BANK_EMPTY;
        rd_bank             <= BANK_W'(next_bank(int'(rd_bank), NUM_BANKS));
      end
      case ({wr_commit, rd_release})
        2'b10:   full_count <= full_count + CNT_W'(1);
        2'b01:   full_count <= full_count - CNT_W'(1);
        default: full_count <= full_count;
      endcase
      rd_valid <= rd_fire;
      rd_err   <= rd_en && !rd_avail;
      if (rd_fire) rd_bank_q <= rd_bank;
      if (rd_valid) rd_hold <= rd_data;
    end
  end

  a_strb_nonzero: assert property (@(posedge clk) disable iff (rst)
    wr_fire |-> (wr_strb != '0))
    else $warning("write beat with all byte strobes clear");

  a_count_matches: assert property (@(posedge clk) disable iff (rst)
    full_count == CNT_W'($countones(bank_full)));

endmodule

// File: tb/tb_act_buffer_nbank.sv
// Self-checking bench for act_buffer_nbank: behavioural bank model plus read-data scoreboard.
module tb_act_buffer_nbank;

  localparam int NB = 4;
  localparam int TM = 16;
  localparam int AW = 7;
  localparam int W  = TM * 8;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          wr_valid, wr_last, rd_en, rd_last;
  logic          wr_ready, rd_avail, rd_valid, rd_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data, rd_data;
  logic [TM-1:0] wr_strb;
  logic [1:0]    wr_bank, rd_bank;
  logic [2:0]    full_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem [NB][2**AW];
  bit           m_full [NB];
  int           m_wr, m_rd, m_cnt;

  act_buffer_nbank #(.NUM_BANKS(NB), .TM(TM), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_last(wr_last),
    .rd_en(rd_en), .rd_avail(rd_avail), .rd_addr(rd_addr), .rd_last(rd_last),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .full_count(full_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 data=%h, no read expected", rd_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_last = 0;
    rd_en = 0; rd_addr = '0; rd_last = 0; flush = 0;
  endtask

  // One clock of stimulus, called at a negedge; returns at the following negedge.
  task automatic cycle(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [TM-1:0] ws, input logic wl,
                       input logic re, input logic [AW-1:0] ra, input logic rl,
                       input logic fl);
    bit wfire, rfire;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws; wr_last = wl;
    rd_en = re; rd_addr = ra; rd_last = rl; flush = fl;
    wfire = wv && !m_full[m_wr] && !fl;
    rfire = re && m_full[m_rd] && !fl;
    if (rfire) exp_q.push_back(model_mem[m_rd][ra]);
    @(posedge clk);
    if (fl) begin
      for (int b = 0; b < NB; b++) m_full[b] = 0;
      m_wr = 0; m_rd = 0; m_cnt = 0;
    end else begin
      if (wfire) begin
        for (int i = 0; i < TM; i++)
          if (ws[i]) model_mem[m_wr][wa][i*8 +: 8] = wd[i*8 +: 8];
        if (wl) begin
          m_full[m_wr] = 1; m_wr = (m_wr + 1) % NB; m_cnt++;
        end
      end
      if (rfire && rl) begin
        m_full[m_rd] = 0; m_rd = (m_rd + 1) % NB; m_cnt--;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic write_beat(input logic [AW-1:0] a, input logic [W-1:0] d,
                            input logic [TM-1:0] s, input logic l);
    cycle(1, a, d, s, l, 0, '0, 0, 0);
  endtask

  task automatic read_beat(input logic [AW-1:0] a, input logic l);
    cycle(0, '0, '0, '0, 0, 1, a, l, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int b = 0; b < NB; b++) m_full[b] = 0;
    m_wr = 0; m_rd = 0; m_cnt = 0;
    checks++; if (full_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", full_count); end
    checks++; if (wr_bank !== 2'd0 || rd_bank !== 2'd0) begin errors++; $display("FAIL reset_ptrs: wr=%0d rd=%0d expected 0/0", wr_bank, rd_bank); end
    checks++; if (wr_ready !== 1'b1 || rd_avail !== 1'b0) begin errors++; $display("FAIL reset_flags: wr_ready=%b rd_avail=%b expected 1/0", wr_ready, rd_avail); end
    checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL reset_rd: valid=%b err=%b data=%h expected 0/0/0", rd_valid, rd_err, rd_data); end
  endtask

  task automatic test_first_fill();
    write_beat(7'd3, rand_word(), '1, 0);
    write_beat(7'd4, rand_word(), '1, 0);
    write_beat(7'd5, rand_word(), '1, 1);
    checks++; if (full_count !== 3'd1) begin errors++; $display("FAIL fill1_count: got %0d expected 1", full_count); end
    checks++; if (wr_bank !== 2'd1) begin errors++; $display("FAIL fill1_wr_bank: got %0d expected 1", wr_bank); end
    checks++; if (rd_avail !== 1'b1) begin errors++; $display("FAIL fill1_rd_avail: got %b expected 1", rd_avail); end
  endtask

  task automatic test_fill_all();
    for (int b = 1; b < NB; b++)
      for (int a = 0; a < 8; a++) write_beat(AW'(a), rand_word(), '1, a == 7);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (full_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", full_count); end
    write_beat(7'd5, rand_word(), '1, 1);  // refused: bank0 is full
    checks++; if (full_count !== 3'd4 || wr_bank !== 2'd0) begin errors++; $display("FAIL blocked_write: count=%0d wr_bank=%0d expected 4/0", full_count, wr_bank); end
    read_beat(7'd5, 0);
  endtask

  task automatic test_read_release();
    read_beat(7'd5, 1);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_bank !== 2'd1 || full_count !== 3'd3) begin errors++; $display("FAIL release_state: rd_bank=%0d count=%0d expected 1/3", rd_bank, full_count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_wr_ready: got %b expected 1", wr_ready); end
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", rd_valid); end
  endtask

  task automatic test_strobe();
    logic [W-1:0] exp_word;
    exp_word = '1;
    exp_word[7:0] = 8'h00;
    write_beat(7'd2, '1, '1, 0);
    write_beat(7'd2, '0, 16'h0001, 1);
    for (int b = 1; b < NB; b++) read_beat(7'd0, 1);
    read_beat(7'd2, 1);
    checks++; if (rd_data !== exp_word) begin errors++; $display("FAIL strobe_word: got %h expected %h", rd_data, exp_word); end
    checks++; if (full_count !== 3'd0 || rd_avail !== 1'b0) begin errors++; $display("FAIL drained: count=%0d rd_avail=%b expected 0/0", full_count, rd_avail); end
  endtask

  task automatic test_empty_read();
    read_beat(7'd0, 0);
    checks++; if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL empty_read: err=%b valid=%b expected 1/0", rd_err, rd_valid); end
    @(negedge clk);
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b expected 0", rd_err); end
  endtask

  task automatic test_commit_release();
    write_beat(7'd9, rand_word(), '1, 1);
    cycle(1, 7'd9, rand_word(), '1, 1, 1, 7'd9, 1, 0);
    checks++; if (full_count !== AW'(m_cnt) || full_count !== 3'd1) begin errors++; $display("FAIL same_cycle_count: got %0d expected 1", full_count); end
    checks++; if (wr_bank !== 2'd3 || rd_bank !== 2'd2) begin errors++; $display("FAIL same_cycle_ptrs: wr=%0d rd=%0d expected 3/2", wr_bank, rd_bank); end
  endtask

  task automatic test_flush();
    write_beat(7'd9, rand_word(), '1, 1);
    write_beat(7'd1, rand_word(), '1, 0);
    checks++; if (full_count !== 3'd2) begin errors++; $display("FAIL preflush_count: got %0d expected 2", full_count); end
    cycle(1, 7'd1, rand_word(), '1, 1, 1, 7'd9, 1, 1);
    checks++; if (full_count !== 3'd0 || wr_bank !== 2'd0 || rd_bank !== 2'd0) begin errors++; $display("FAIL flush_state: count=%0d wr=%0d rd=%0d expected 0/0/0", full_count, wr_bank, rd_bank); end
    checks++; if (rd_avail !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL flush_flags: rd_avail=%b wr_ready=%b expected 0/1", rd_avail, wr_ready); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL flush_rd: valid=%b data=%h expected 0/0", rd_valid, rd_data); end
  endtask

  task automatic test_laps();
    logic [AW-1:0] a0, a1;
    for (int lap = 0; lap < 5; lap++) begin
      a0 = AW'($urandom_range(0, 63));
      a1 = a0 + AW'(64);
      for (int b = 0; b < NB; b++) begin
        write_beat(a0, rand_word(), '1, 0);
        write_beat(a1, rand_word(), AW'($urandom_range(1, 127)) == 0 ? '1 : 16'hFFFF, 1);
      end
      checks++; if (full_count !== 3'd4 || wr_bank !== 2'd0) begin errors++; $display("FAIL lap%0d_full: count=%0d wr=%0d expected 4/0", lap, full_count, wr_bank); end
      for (int b = 0; b < NB; b++) begin
        read_beat(a1, 0);
        read_beat(a0, 1);
      end
      checks++; if (full_count !== 3'd0 || rd_bank !== 2'd0) begin errors++; $display("FAIL lap%0d_empty: count=%0d rd=%0d expected 0/0", lap, full_count, rd_bank); end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_first_fill();
    test_fill_all();
    test_read_release();
    test_strobe();
    test_empty_read();
    test_commit_release();
    test_flush();
    test_laps();
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
